// File: rtl/seq_bit_entry.sv
// Board-input front end: synchronises and debounces the entry switches and buttons into
// clean detector stimulus. Define SEQ_BIT_ENTRY_AUTOREPEAT_EN to build held-enter auto-repeat.
module seq_bit_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_bit,
  input  logic       btn_enter,
  input  logic       btn_load,
  input  logic [7:0] seq_sw,
  output logic       in_bit,
  output logic       bit_valid,
  output logic [7:0] seq_out,
  output logic       seq_load,
  output logic [7:0] bit_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int SW  = 0;
  localparam int ENT = 1;
  localparam int LD  = 2;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("seq_bit_entry: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  logic [RW-1:0] rep_cnt_q;
`else
  typedef enum logic {IDLE, PRESSED} state_t;
`endif

  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [7:0]          seq_sync1_q, seq_sync2_q;
  logic [2:0]          clean_q, clean_d;
  logic [2:0][CW-1:0]  cnt_q, cnt_d;
  logic                enter_rise, enter_fall, load_rise, accept;
  state_t              state_q;
  logic                in_bit_q, bit_valid_q, seq_load_q;
  logic [7:0]          seq_out_q, bit_count_q;

  assign raw = {btn_load, btn_enter, sw_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      seq_sync1_q <= '0;
      seq_sync2_q <= '0;
      clean_q     <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      seq_sync1_q <= seq_sw;
      seq_sync2_q <= seq_sync1_q;
      clean_q     <= clean_d;
      cnt_q       <= cnt_d;
    end
  end

  // A change is only taken once the synced input has differed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        clean_d[i] = ~clean_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edges are taken from the debouncer's next state so the strobe lands in the flip cycle.
  assign enter_rise = clean_d[ENT] & ~clean_q[ENT];
  assign enter_fall = ~clean_d[ENT] & clean_q[ENT];
  assign load_rise  = clean_d[LD] & ~clean_q[LD];

  always_comb begin
    accept = 1'b0;
    case (state_q)
      IDLE:    accept = enter_rise;
`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
      PRESSED,
      REPEAT:  accept = !enter_fall && (rep_cnt_q == REP_LAST);
`endif
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_bit_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      seq_out_q   <= '0;
      seq_load_q  <= 1'b0;
      bit_count_q <= '0;
`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      bit_valid_q <= accept;
      seq_load_q  <= load_rise;
      if (accept) begin
        in_bit_q <= clean_q[SW];
      end
      if (load_rise) begin
        seq_out_q   <= seq_sync2_q;
        bit_count_q <= '0;
      end else if (accept) begin
        bit_count_q <= bit_count_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (enter_rise) begin
            state_q <= PRESSED;
          end
`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
          rep_cnt_q <= '0;
`endif
        end
`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
        PRESSED, REPEAT: begin
          if (enter_fall) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == REP_LAST) begin
            state_q   <= REPEAT;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + RW'(1);
          end
        end
`else
        PRESSED: begin
          if (enter_fall) begin
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_bit    = in_bit_q;
  assign bit_valid = bit_valid_q;
  assign seq_out   = seq_out_q;
  assign seq_load  = seq_load_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_seq_bit_entry.sv
// Scoreboard bench for seq_bit_entry: each driven press queues its expected strobe,
// and a negedge monitor pops and compares whenever the DUT strobes.
module tb_seq_bit_entry;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw_bit = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_load = 1'b0;
  logic [7:0] seq_sw = 8'h00;
  logic       in_bit, bit_valid, seq_load;
  logic [7:0] seq_out, bit_count;

  seq_bit_entry #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset), .sw_bit(sw_bit), .btn_enter(btn_enter),
    .btn_load(btn_load), .seq_sw(seq_sw), .in_bit(in_bit), .bit_valid(bit_valid),
    .seq_out(seq_out), .seq_load(seq_load), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_no;
    logic       bit_val;
    logic [7:0] count;
  } bit_exp_t;

  typedef struct {
    int         edge_no;
    logic [7:0] seq;
  } load_exp_t;

  bit_exp_t   bit_q[$];
  load_exp_t  load_q[$];
  logic [7:0] exp_count = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobes appear in the cycle after the posedge that raised them, so cyc equals that edge here.
  always @(negedge clk) begin : monitor
    bit_exp_t  be;
    load_exp_t le;
    if (bit_valid === 1'b1) begin
      if (bit_q.size() == 0) begin
        checkOutput("unexpected_bit_valid", bit_valid, 1'b0);
      end else begin
        be = bit_q.pop_front();
        checkOutput("bit_valid_edge", cyc, be.edge_no);
        checkOutput("in_bit", in_bit, be.bit_val);
        checkOutput("bit_count", bit_count, be.count);
      end
    end
    if (seq_load === 1'b1) begin
      if (load_q.size() == 0) begin
        checkOutput("unexpected_seq_load", seq_load, 1'b0);
      end else begin
        le = load_q.pop_front();
        checkOutput("seq_load_edge", cyc, le.edge_no);
        checkOutput("seq_out", seq_out, le.seq);
        checkOutput("bit_count_after_load", bit_count, 8'h00);
      end
    end
  end

  task automatic applyStimulus(input logic ent, input logic ld, input logic sw,
                               input logic [7:0] seq, input int hold, input int reps);
    int n;
    @(negedge clk);
    sw_bit = sw;
    seq_sw = seq;
    repeat (DEB + 3) @(negedge clk);
    btn_enter = ent;
    btn_load  = ld;
    n = cyc + 1;
    if (ld) begin
      exp_count = 8'h00;
      load_q.push_back('{edge_no: n + 1 + DEB, seq: seq});
    end
    if (ent) begin
      if (!ld) exp_count = exp_count + 8'd1;
      bit_q.push_back('{edge_no: n + 1 + DEB, bit_val: sw, count: exp_count});
      for (int r = 1; r <= reps; r++) begin
        exp_count = exp_count + 8'd1;
        bit_q.push_back('{edge_no: n + 1 + DEB + r * REP, bit_val: sw, count: exp_count});
      end
    end
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    btn_load  = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int nrep;
    nrep = 0;
`ifdef SEQ_BIT_ENTRY_AUTOREPEAT_EN
    nrep = 3;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_in_bit", in_bit, 1'b0);
    checkOutput("reset_bit_valid", bit_valid, 1'b0);
    checkOutput("reset_seq_out", seq_out, 8'h00);
    checkOutput("reset_seq_load", seq_load, 1'b0);
    checkOutput("reset_bit_count", bit_count, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] clean press, held 20 cycles");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 20, 0);

    $display("[TB] short glitch rejected");
    btn_enter = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btn_enter = 1'b0;
    repeat (DEB + 6) @(negedge clk);

    $display("[TB] bouncing press: 3 high, 1 low, then held");
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    @(negedge clk);
    btn_enter = 1'b1;
    n = cyc + 1;
    exp_count = exp_count + 8'd1;
    bit_q.push_back('{edge_no: n + 1 + DEB, bit_val: 1'b1, count: exp_count});
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    $display("[TB] three bits then load 0xA5, then load together with enter");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, DEB + 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, DEB + 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, DEB + 2, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, DEB + 2, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C, DEB + 2, 0);

    $display("[TB] asynchronous reset during a held press");
    @(negedge clk);
    sw_bit = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    btn_enter = 1'b1;
    n = cyc + 1;
    exp_count = exp_count + 8'd1;
    bit_q.push_back('{edge_no: n + 1 + DEB, bit_val: 1'b1, count: exp_count});
    repeat (DEB + 4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_in_bit", in_bit, 1'b0);
    checkOutput("async_reset_bit_valid", bit_valid, 1'b0);
    checkOutput("async_reset_seq_out", seq_out, 8'h00);
    checkOutput("async_reset_seq_load", seq_load, 1'b0);
    checkOutput("async_reset_bit_count", bit_count, 8'h00);
    exp_count = 8'h00;
    btn_enter = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] long hold: auto-repeat strobes only when built in");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 55, nrep);

    $display("[TB] 256 presses wrap bit_count");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A, DEB + 2, 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'h5A, DEB + 2, 0);
    end
    checkOutput("wrap_bit_count", bit_count, 8'h00);

    repeat (20) @(negedge clk);
    checkOutput("pending_bit_strobes", bit_q.size(), 0);
    checkOutput("pending_load_strobes", load_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
